// File: rtl/motion_sequencer.sv
// motion_sequencer: ramped two-wheel duty sequencer with lost-line search and halt
// Ports: i_clk/i_reset (async, active-high), i_enable, i_track_state (tracker policy code),
//        i_sensors {left,mid,right}, i_modulation_left/right (forward duty ceilings),
//        o_duty_left/right (registered duty), o_dir_left/right (1 = forward),
//        o_mode (IDLE/RUN/SEARCH/HALT), o_halted.
module motion_sequencer #(
    parameter int RAMP_DIV       = 16,
    parameter int RAMP_STEP      = 8,
    parameter int TURN_SPEED     = 600,
    parameter int SHARP_SPEED    = 300,
    parameter int SEARCH_SPEED   = 400,
    parameter int LOST_CYCLES    = 50000,
    parameter int SEARCH_TIMEOUT = 5000000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [2:0] i_track_state,
    input  logic [2:0] i_sensors,
    input  logic [9:0] i_modulation_left,
    input  logic [9:0] i_modulation_right,
    output logic [9:0] o_duty_left,
    output logic [9:0] o_duty_right,
    output logic       o_dir_left,
    output logic       o_dir_right,
    output logic [1:0] o_mode,
    output logic       o_halted
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, SEARCH = 2'b10, HALT = 2'b11} mode_t;
    localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    localparam int LW = $clog2(LOST_CYCLES + 1);
    localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [9:0] STEP = 10'(RAMP_STEP);
    localparam logic [9:0] TURN = 10'(TURN_SPEED);
    localparam logic [9:0] SHARP = 10'(SHARP_SPEED);
    localparam logic [9:0] SPIN = 10'(SEARCH_SPEED);
    mode_t r_mode, w_mode_nxt;
    logic [PW-1:0] r_pre;
    logic [LW-1:0] r_lost, w_lost_nxt;
    logic [SW-1:0] r_search, w_search_nxt;
    logic r_side;
    logic [9:0] r_duty_l, r_duty_r, w_tgt_l, w_tgt_r, w_cap_l, w_cap_r;
    logic r_dir_l, r_dir_r, w_tdir_l, w_tdir_r, w_step, w_no_line;
    logic [10:0] w_ramp_l, w_ramp_r;
    // A wheel whose target direction differs must reach 0 before its dir bit may flip;
    // the flip itself consumes one ramp step.
    function automatic logic [10:0] ramp(input logic [9:0] duty, input logic dir,
                                         input logic [9:0] tgt, input logic tdir);
        if (tdir != dir)
            return duty == 10'd0 ? {tdir, 10'd0} : {dir, duty > STEP ? duty - STEP : 10'd0};
        if (tgt > duty)
            return {dir, tgt - duty <= STEP ? tgt : duty + STEP};
        return {dir, duty - tgt <= STEP ? tgt : duty - STEP};
    endfunction
    assign w_step = r_pre == PW'(RAMP_DIV - 1);
    assign w_no_line = i_sensors == 3'b000;
    assign w_cap_l = i_modulation_left < TURN ? i_modulation_left : TURN;
    assign w_cap_r = i_modulation_right < TURN ? i_modulation_right : TURN;
    assign w_ramp_l = ramp(r_duty_l, r_dir_l, w_tgt_l, w_tdir_l);
    assign w_ramp_r = ramp(r_duty_r, r_dir_r, w_tgt_r, w_tdir_r);
    assign o_duty_left = r_duty_l;
    assign o_duty_right = r_duty_r;
    assign o_dir_left = r_dir_l;
    assign o_dir_right = r_dir_r;
    assign o_mode = r_mode;
    assign o_halted = r_mode == HALT;
    always_comb begin
        w_lost_nxt = (i_enable && r_mode == RUN && w_no_line) ?
                     (r_lost == LW'(LOST_CYCLES) ? r_lost : r_lost + LW'(1)) : '0;
        // Leaving RUN with a zero here is what clears the search counter on entry.
        w_search_nxt = (i_enable && r_mode == SEARCH) ?
                       (r_search == SW'(SEARCH_TIMEOUT) ? r_search : r_search + SW'(1)) : '0;
        w_mode_nxt = !i_enable ? IDLE :
                     r_mode == IDLE ? RUN :
                     r_mode == RUN ? (w_lost_nxt == LW'(LOST_CYCLES) ? SEARCH : RUN) :
                     r_mode == SEARCH ? (!w_no_line ? RUN :
                                         w_search_nxt == SW'(SEARCH_TIMEOUT) ? HALT : SEARCH) :
                     HALT;
    end
    always_comb begin
        w_tgt_l = '0;
        w_tgt_r = '0;
        w_tdir_l = 1'b1;
        w_tdir_r = 1'b1;
        if (r_mode == RUN) begin
            case (i_track_state)
                3'b000: begin w_tgt_l = w_cap_l; w_tgt_r = i_modulation_right; end
                3'b001: begin w_tgt_l = i_modulation_left; w_tgt_r = w_cap_r; end
                3'b010: begin w_tgt_l = i_modulation_left; w_tgt_r = i_modulation_right; end
                3'b100: begin w_tgt_l = SHARP; w_tdir_l = 1'b0; w_tgt_r = i_modulation_right; end
                3'b101: begin w_tgt_l = i_modulation_left; w_tgt_r = SHARP; w_tdir_r = 1'b0; end
                default: ;
            endcase
        end else if (r_mode == SEARCH) begin
            // r_side: 0 = LEFT spins left wheel backward, 1 = RIGHT spins right wheel backward
            w_tgt_l = SPIN;
            w_tgt_r = SPIN;
            w_tdir_l = r_side;
            w_tdir_r = ~r_side;
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_mode <= IDLE;
        else r_mode <= w_mode_nxt;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pre <= '0;
            r_lost <= '0;
            r_search <= '0;
            r_side <= 1'b0;
            r_duty_l <= '0;
            r_duty_r <= '0;
            r_dir_l <= 1'b1;
            r_dir_r <= 1'b1;
        end else begin
            r_pre <= w_step ? '0 : r_pre + PW'(1);
            r_lost <= w_lost_nxt;
            r_search <= w_search_nxt;
            // Codes 000/001/100/101 are the turns: bit1 clear, bit0 selects the side.
            if (r_mode == RUN && !i_track_state[1]) r_side <= i_track_state[0];
            if (!i_enable || r_mode == IDLE) begin
                r_duty_l <= '0;
                r_duty_r <= '0;
                r_dir_l <= 1'b1;
                r_dir_r <= 1'b1;
            end else if (w_step) begin
                {r_dir_l, r_duty_l} <= w_ramp_l;
                {r_dir_r, r_duty_r} <= w_ramp_r;
            end
        end
    end
endmodule
